// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with per-frame input snapshot.
// Optional build macro SSEG_LZB_EN enables leading-zero blanking in numeric mode.
module sseg_scan_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ltr_flag,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

  generate
    if (DIV < 2 || DIV <= BLANK_CYCLES) begin : g_bad_cfg
      $error("sseg_scan_driver: DIV must be >= 2 and greater than BLANK_CYCLES");
    end
  endgenerate

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_sh_dig [4];
  logic          r_sh_ltr;
  logic [3:0]    r_sh_dp;
  logic [3:0]    r_an;
  logic [7:0]    r_sseg;
  logic          r_frame_tick;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [3:0]    w_snap_dig [4];
  logic [3:0]    w_cur_dig;
  logic [6:0]    w_seg;

  // gfedcba, active-low; code 4'hF is blank in both tables.
  function automatic logic [6:0] seg7(input logic ltr, input logic [3:0] code);
    logic [6:0] s;
    s = 7'b1111111;
    if (!ltr) begin
      case (code)
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hA: s = 7'b0001000;
        4'hB: s = 7'b0000011;
        4'hC: s = 7'b1000110;
        4'hD: s = 7'b0100001;
        4'hE: s = 7'b0000110;
        default: s = 7'b1111111;
      endcase
    end else begin
      case (code)
        4'h5: s = 7'b0001001;
        4'hA: s = 7'b1111001;
        4'h1: s = 7'b1000111;
        4'h0: s = 7'b1000000;
        4'h2: s = 7'b0001100;
        4'h3: s = 7'b0000110;
        4'h4: s = 7'b0101111;
        4'h8: s = 7'b0010010;
        default: s = 7'b1111111;
      endcase
    end
    return s;
  endfunction

  assign w_slot_end  = (r_presc == LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);

`ifdef SSEG_LZB_EN
  logic w_blank3;
  logic w_blank2;
  logic w_blank1;
  assign w_blank3 = !ltr_flag && (digit3 == 4'h0);
  assign w_blank2 = w_blank3 && (digit2 == 4'h0);
  assign w_blank1 = w_blank2 && (digit1 == 4'h0);
`endif

  // Values loaded into the shadow registers at the frame boundary.
  always_comb begin
    w_snap_dig[0] = digit0;
    w_snap_dig[1] = digit1;
    w_snap_dig[2] = digit2;
    w_snap_dig[3] = digit3;
`ifdef SSEG_LZB_EN
    if (w_blank3) w_snap_dig[3] = 4'hF;
    if (w_blank2) w_snap_dig[2] = 4'hF;
    if (w_blank1) w_snap_dig[1] = 4'hF;
`endif
  end

  assign w_cur_dig = r_sh_dig[r_idx];
  assign w_seg     = seg7(r_sh_ltr, w_cur_dig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_sh_dig[0]  <= 4'hF;
      r_sh_dig[1]  <= 4'hF;
      r_sh_dig[2]  <= 4'hF;
      r_sh_dig[3]  <= 4'hF;
      r_sh_ltr     <= 1'b0;
      r_sh_dp      <= 4'h0;
      r_an         <= 4'hF;
      r_sseg       <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= w_slot_end ? '0 : r_presc + PW'(1);
      r_frame_tick <= w_frame_end;
      if (w_slot_end) r_idx <= r_idx + 2'd1;
      if (w_frame_end) begin
        r_sh_dig[0] <= w_snap_dig[0];
        r_sh_dig[1] <= w_snap_dig[1];
        r_sh_dig[2] <= w_snap_dig[2];
        r_sh_dig[3] <= w_snap_dig[3];
        r_sh_ltr    <= ltr_flag;
        r_sh_dp     <= dp_in;
      end
      // Guard interval at slot start keeps the previous digit from ghosting.
      if (r_presc < BLANK) begin
        r_an   <= 4'hF;
        r_sseg <= 8'hFF;
      end else begin
        r_an   <= ~(4'b0001 << r_idx);
        r_sseg <= {~r_sh_dp[r_idx], w_seg};
      end
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed self-checking bench for sseg_scan_driver (DIV=10, BLANK_CYCLES=2).
// Expectations for leading-zero blanking follow the SSEG_LZB_EN build macro.
module tb_sseg_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       ltr_flag;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_seg [4];
  logic [3:0] cap_an [4];
  bit         tick_ok;
  logic [3:0] one = 4'b0001;

  logic [7:0] exp_num [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'hFF};
  logic [7:0] exp_ltr [16] = '{8'hC0, 8'hC7, 8'h8C, 8'h86, 8'hAF, 8'h89, 8'hFF, 8'hFF,
                               8'h92, 8'hFF, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .CLK_HZ      (1000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ltr_flag  (ltr_flag),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .dp_in     (dp_in),
    .an        (an),
    .sseg      (sseg),
    .frame_tick(frame_tick)
  );

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic l, input logic [3:0] dp);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    ltr_flag = l; dp_in = dp;
  endtask

  task automatic wait_tick();
    int n;
    tick_ok = 1'b0;
    n = 0;
    while (!tick_ok && n < 60) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) tick_ok = 1'b1;
    end
  endtask

  // Records one mid-slot sample of each slot of the frame following a tick.
  task automatic capture_frame();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i % 10 == 6) begin
        cap_seg[i/10] = sseg;
        cap_an[i/10]  = an;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_inputs(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL reset_an: got %b expected 1111", an); end
    n_cmp++; if (sseg !== 8'hFF) begin n_bad++; $display("FAIL reset_sseg: got %h expected ff", sseg); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    rst = 1'b0;
  endtask

  // Must follow reset release immediately: k counts posedges since release.
  task automatic test_scan_timing(input string tag);
    logic [3:0] e_an;
    int slot, p;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      slot = ((k - 1) / 10) % 4;
      p    = (k - 1) % 10;
      e_an = (p < 2) ? 4'hF : ~(one << slot);
      n_cmp++;
      if (an !== e_an) begin
        n_bad++; $display("FAIL %s_an[k=%0d]: got %b expected %b", tag, k, an, e_an);
      end
      n_cmp++;
      if (k <= 40 && sseg !== 8'hFF) begin
        n_bad++; $display("FAIL %s_sseg[k=%0d]: got %h expected ff", tag, k, sseg);
      end
      n_cmp++;
      if (frame_tick !== (k % 40 == 0)) begin
        n_bad++; $display("FAIL %s_tick[k=%0d]: got %b expected %b", tag, k, frame_tick, (k % 40 == 0));
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    wait_tick();
    n_cmp++; if (!tick_ok) begin n_bad++; $display("FAIL %s_tick_timeout: got 0 expected 1", tag); end
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (cap_seg[s] !== e[s]) begin
        n_bad++; $display("FAIL %s_seg[%0d]: got %h expected %h", tag, s, cap_seg[s], e[s]);
      end
      n_cmp++;
      if (cap_an[s] !== ~(one << s)) begin
        n_bad++; $display("FAIL %s_an[%0d]: got %b expected %b", tag, s, cap_an[s], ~(one << s));
      end
    end
  endtask

  task automatic test_tables();
    for (int f = 0; f < 4; f++) begin
      set_inputs(4'(4*f+3), 4'(4*f+2), 4'(4*f+1), 4'(4*f), 1'b0, 4'h0);
      check_frame($sformatf("num%0d", f), exp_num[4*f+3], exp_num[4*f+2], exp_num[4*f+1], exp_num[4*f]);
    end
    for (int f = 0; f < 4; f++) begin
      set_inputs(4'(4*f+3), 4'(4*f+2), 4'(4*f+1), 4'(4*f), 1'b1, 4'h0);
      check_frame($sformatf("ltr%0d", f), exp_ltr[4*f+3], exp_ltr[4*f+2], exp_ltr[4*f+1], exp_ltr[4*f]);
    end
  endtask

  task automatic test_letter_hi();
    set_inputs(4'hF, 4'hF, 4'h5, 4'hA, 1'b1, 4'h0);
    check_frame("hi", 8'hFF, 8'hFF, 8'h89, 8'hF9);
  endtask

  task automatic test_dp();
    set_inputs(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1000);
    check_frame("dp1000", 8'h79, 8'hC0, 8'hC0, 8'hC0);
    set_inputs(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'b0101);
    check_frame("dp_blank", 8'hFF, 8'h7F, 8'hFF, 8'h7F);
  endtask

  task automatic test_lzb();
`ifdef SSEG_LZB_EN
    set_inputs(4'h0, 4'h0, 4'h4, 4'h2, 1'b0, 4'h0);
    check_frame("lzb_0042", 8'hFF, 8'hFF, 8'h99, 8'hA4);
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    check_frame("lzb_0000", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1110);
    check_frame("lzb_dp", 8'h7F, 8'h7F, 8'h7F, 8'hC0);
    set_inputs(4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 4'h0);
    check_frame("lzb_0500", 8'hFF, 8'h92, 8'hC0, 8'hC0);
`else
    set_inputs(4'h0, 4'h0, 4'h4, 4'h2, 1'b0, 4'h0);
    check_frame("lzb_0042", 8'hC0, 8'hC0, 8'h99, 8'hA4);
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    check_frame("lzb_0000", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1110);
    check_frame("lzb_dp", 8'h40, 8'h40, 8'h40, 8'hC0);
    set_inputs(4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 4'h0);
    check_frame("lzb_0500", 8'hC0, 8'h92, 8'hC0, 8'hC0);
`endif
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0);
    check_frame("lzb_letter", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
  endtask

  task automatic test_mid_frame();
    set_inputs(4'hF, 4'hF, 4'hF, 4'h7, 1'b0, 4'h0);
    wait_tick();
    n_cmp++; if (!tick_ok) begin n_bad++; $display("FAIL mid_tick_timeout: got 0 expected 1"); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) digit1 = 4'h3;
      if (i == 15) digit0 = 4'h9;
      if (i == 6) begin
        n_cmp++; if (sseg !== 8'hF8) begin n_bad++; $display("FAIL mid_slot0: got %h expected f8", sseg); end
      end
      if (i == 16) begin
        n_cmp++; if (sseg !== 8'hFF) begin n_bad++; $display("FAIL mid_slot1: got %h expected ff", sseg); end
        n_cmp++; if (an !== 4'b1101) begin n_bad++; $display("FAIL mid_an1: got %b expected 1101", an); end
      end
      if (i == 39) begin
        n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL mid_early_tick: got 1 expected 0"); end
      end
      if (i == 40) begin
        n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL mid_tick: got 0 expected 1"); end
      end
    end
    capture_frame();
    n_cmp++; if (cap_seg[0] !== 8'h90) begin n_bad++; $display("FAIL mid_new_d0: got %h expected 90", cap_seg[0]); end
    n_cmp++; if (cap_seg[1] !== 8'hB0) begin n_bad++; $display("FAIL mid_new_d1: got %h expected b0", cap_seg[1]); end
  endtask

  task automatic test_reset_mid_scan();
    set_inputs(4'h8, 4'h8, 4'h8, 4'h8, 1'b0, 4'h0);
    wait_tick();
    n_cmp++; if (!tick_ok) begin n_bad++; $display("FAIL rms_tick_timeout: got 0 expected 1"); end
    repeat (25) @(negedge clk);
    n_cmp++; if (an !== 4'b1011) begin n_bad++; $display("FAIL rms_pre_an: got %b expected 1011", an); end
    n_cmp++; if (sseg !== 8'h80) begin n_bad++; $display("FAIL rms_pre_sseg: got %h expected 80", sseg); end
    rst = 1'b1;
    #1;
    n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL rms_async_an: got %b expected 1111", an); end
    n_cmp++; if (sseg !== 8'hFF) begin n_bad++; $display("FAIL rms_async_sseg: got %h expected ff", sseg); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rms_async_tick: got %b expected 0", frame_tick); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_scan_timing("rms");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_scan_timing("scan");
    test_tables();
    test_letter_hi();
    test_dp();
    test_lzb();
    test_mid_frame();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
